// File: rtl/csr_ctrl.sv
// csr_ctrl: machine-mode CSR file and update sequencer.
// Serialises Zicsr instructions, trap entry and mret onto one write port,
// runs mcycle, samples interrupt lines and publishes all registers.

package csr_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_SATP     = 12'h180;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    // Only MPP[12:11], MPIE[7] and MIE[3] exist in mstatus.
    localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_1888;

    typedef struct packed {
        logic [63:0] mstatus;
        logic [63:0] mie;
        logic [63:0] mtvec;
        logic [63:0] mscratch;
        logic [63:0] mepc;
        logic [63:0] mcause;
        logic [63:0] mtval;
        logic [63:0] mip;
        logic [63:0] mcycle;
        logic [63:0] mhartid;
        logic [63:0] satp;
    } csr_pack;

    // Read a register by address; bit 64 flags an unimplemented address (value 0).
    function automatic logic [64:0] csr_lookup(input csr_pack regs, input logic [11:0] addr);
        logic [64:0] r;
        r = {1'b1, 64'd0};
        case (addr)
            CSR_MSTATUS:  r = {1'b0, regs.mstatus};
            CSR_MIE:      r = {1'b0, regs.mie};
            CSR_MTVEC:    r = {1'b0, regs.mtvec};
            CSR_MSCRATCH: r = {1'b0, regs.mscratch};
            CSR_MEPC:     r = {1'b0, regs.mepc};
            CSR_MCAUSE:   r = {1'b0, regs.mcause};
            CSR_MTVAL:    r = {1'b0, regs.mtval};
            CSR_MIP:      r = {1'b0, regs.mip};
            CSR_SATP:     r = {1'b0, regs.satp};
            CSR_MCYCLE:   r = {1'b0, regs.mcycle};
            CSR_MHARTID:  r = {1'b0, regs.mhartid};
            default:      r = {1'b1, 64'd0};
        endcase
        return r;
    endfunction

    // Zicsr read-modify-write: 01 RW, 10 RS, 11 RC.
    function automatic logic [63:0] csr_modify(input logic [1:0] op, input logic [63:0] old,
                                               input logic [63:0] wdata);
        logic [63:0] r;
        case (op)
            2'b01:   r = wdata;
            2'b10:   r = old | wdata;
            2'b11:   r = old & ~wdata;
            default: r = old;
        endcase
        return r;
    endfunction

endpackage

module csr_ctrl
    import csr_ctrl_pkg::*;
#(
    parameter logic [63:0] HARTID = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ready,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [11:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_illegal,
    input  logic        trap_valid,
    input  logic [63:0] trap_cause,
    input  logic [63:0] trap_pc,
    input  logic [63:0] trap_tval,
    input  logic        mret_valid,
    input  logic        irq_mtip,
    input  logic        irq_msip,
    input  logic        irq_meip,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic        irq_pending,
    output csr_pack     csr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CSR_WB  = 2'd1,
        TRAP_WB = 2'd2,
        MRET_WB = 2'd3
    } state_t;

    state_t      state_q, state_d;
    csr_pack     csr_q, csr_d;
    logic [1:0]  op_q, op_d;
    logic [11:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;     // CSR wdata, or trap cause
    logic [63:0] old_q, old_d;         // CSR old value, or trap pc
    logic [63:0] tval_q, tval_d;
    logic [63:0] tgt_q, tgt_d;         // redirect target for TRAP_WB / MRET_WB
    logic        illegal_q, illegal_d;
    logic [64:0] lookup_s;
    logic [63:0] wr_s;

    // Next-state, capture and register-update logic.
    always_comb begin
        state_d   = state_q;
        csr_d     = csr_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        old_d     = old_q;
        tval_d    = tval_q;
        tgt_d     = tgt_q;
        illegal_d = illegal_q;
        lookup_s  = csr_lookup(csr_q, req_addr);
        wr_s      = csr_modify(op_q, old_q, wdata_q);

        csr_d.mcycle = csr_q.mcycle + 64'd1;
        csr_d.mip    = {52'd0, irq_meip, 3'd0, irq_mtip, 3'd0, irq_msip, 3'd0};

        case (state_q)
            IDLE: begin
                if (trap_valid) begin
                    wdata_d = trap_cause;
                    old_d   = trap_pc;
                    tval_d  = trap_tval;
                    if ((csr_q.mtvec[1:0] == 2'b01) && trap_cause[63]) begin
                        tgt_d = {csr_q.mtvec[63:2], 2'b00} + {56'd0, trap_cause[5:0], 2'b00};
                    end else begin
                        tgt_d = {csr_q.mtvec[63:2], 2'b00};
                    end
                    state_d = TRAP_WB;
                end else if (mret_valid) begin
                    tgt_d   = csr_q.mepc;
                    state_d = MRET_WB;
                end else if (req_valid && (req_op != 2'b00)) begin
                    op_d      = req_op;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    old_d     = lookup_s[63:0];
                    illegal_d = lookup_s[64];
                    state_d   = CSR_WB;
                end else begin
                    state_d = IDLE;
                end
            end
            CSR_WB: begin
                if (!illegal_q) begin
                    case (addr_q)
                        CSR_MSTATUS:  csr_d.mstatus  = wr_s & MSTATUS_WMASK;
                        CSR_MIE:      csr_d.mie      = wr_s;
                        CSR_MTVEC:    csr_d.mtvec    = wr_s;
                        CSR_MSCRATCH: csr_d.mscratch = wr_s;
                        CSR_MEPC:     csr_d.mepc     = {wr_s[63:2], 2'b00};
                        CSR_MCAUSE:   csr_d.mcause   = wr_s;
                        CSR_MTVAL:    csr_d.mtval    = wr_s;
                        CSR_SATP:     csr_d.satp     = wr_s;
                        CSR_MCYCLE:   csr_d.mcycle   = wr_s;
                        default:      csr_d.satp     = csr_q.satp;  // mip, mhartid: read-only
                    endcase
                end else begin
                    csr_d.satp = csr_q.satp;
                end
                state_d = IDLE;
            end
            TRAP_WB: begin
                csr_d.mepc    = {old_q[63:2], 2'b00};
                csr_d.mcause  = wdata_q;
                csr_d.mtval   = tval_q;
                csr_d.mstatus = {51'd0, 2'b11, 3'd0, csr_q.mstatus[3], 3'd0, 1'b0, 3'd0};
                state_d       = IDLE;
            end
            MRET_WB: begin
                csr_d.mstatus = {51'd0, 2'b00, 3'd0, 1'b1, 3'd0, csr_q.mstatus[7], 3'd0};
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and register file flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            csr_q         <= '0;
            csr_q.mhartid <= HARTID;
            op_q          <= 2'b00;
            addr_q        <= 12'd0;
            wdata_q       <= 64'd0;
            old_q         <= 64'd0;
            tval_q        <= 64'd0;
            tgt_q         <= 64'd0;
            illegal_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            csr_q     <= csr_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            old_q     <= old_d;
            tval_q    <= tval_d;
            tgt_q     <= tgt_d;
            illegal_q <= illegal_d;
        end
    end

    // Strobes come from the registered state and are masked while reset is high.
    always_comb begin
        ready          = (state_q == IDLE) && !reset;
        resp_valid     = (state_q == CSR_WB) && !reset;
        redirect_valid = ((state_q == TRAP_WB) || (state_q == MRET_WB)) && !reset;
        if (resp_valid) begin
            resp_rdata   = old_q;
            resp_illegal = illegal_q;
        end else begin
            resp_rdata   = 64'd0;
            resp_illegal = 1'b0;
        end
        if (redirect_valid) begin
            redirect_pc = tgt_q;
        end else begin
            redirect_pc = 64'd0;
        end
        irq_pending = csr_q.mstatus[3] && (|(csr_q.mip & csr_q.mie));
        csr         = csr_q;
    end

endmodule

// File: tb/tb_csr_ctrl.sv
// Self-checking bench for csr_ctrl: table of CSR instructions plus
// hand-written trap/mret/priority/reset sequences, with response and
// redirect scoreboards.
module tb_csr_ctrl;
    import csr_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [11:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_illegal;
    logic        trap_valid;
    logic [63:0] trap_cause;
    logic [63:0] trap_pc;
    logic [63:0] trap_tval;
    logic        mret_valid;
    logic        irq_mtip, irq_msip, irq_meip;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        irq_pending;
    csr_pack     csr;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        chk_rd;
        logic        ill;
        logic [63:0] rd;
    } resp_t;

    resp_t       resp_q[$];
    logic [63:0] redir_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rd;
        logic        exp_ill;
        logic        has_after;
        logic [63:0] exp_after;
    } vec_t;

    vec_t vecs[14];

    csr_ctrl #(.HARTID(64'd5)) dut (
        .clk(clk), .reset(reset), .ready(ready),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_illegal(resp_illegal),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
        .mret_valid(mret_valid),
        .irq_mtip(irq_mtip), .irq_msip(irq_msip), .irq_meip(irq_meip),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .irq_pending(irq_pending), .csr(csr)
    );

    always #5 clk = ~clk;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] field_of(input csr_pack p, input logic [11:0] a);
        case (a)
            12'h300: return p.mstatus;
            12'h304: return p.mie;
            12'h305: return p.mtvec;
            12'h340: return p.mscratch;
            12'h341: return p.mepc;
            12'h342: return p.mcause;
            12'h343: return p.mtval;
            12'h344: return p.mip;
            12'h180: return p.satp;
            12'hB00: return p.mcycle;
            12'hF14: return p.mhartid;
            default: return 64'd0;
        endcase
    endfunction

    // Response and redirect scoreboards, sampled on the falling edge.
    always @(negedge clk) begin
        if (resp_valid || redirect_valid) begin
            check64("strobe_exclusive", {63'd0, resp_valid & redirect_valid}, 64'd0);
        end
        if (resp_valid) begin
            if (resp_q.size() == 0) begin
                check64("resp_unexpected", 64'd1, 64'd0);
            end else begin
                resp_t e;
                e = resp_q.pop_front();
                check64("resp_illegal", {63'd0, resp_illegal}, {63'd0, e.ill});
                if (e.chk_rd) check64("resp_rdata", resp_rdata, e.rd);
            end
        end
        if (redirect_valid) begin
            if (redir_q.size() == 0) begin
                check64("redirect_unexpected", 64'd1, 64'd0);
            end else begin
                logic [63:0] ep;
                ep = redir_q.pop_front();
                check64("redirect_pc", redirect_pc, ep);
            end
        end
    end

    task automatic wait_accept(input string name, output logic ok);
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        if (!ok) check64(name, 64'd0, 64'd1);
    endtask

    task automatic settle();
        @(posedge clk); #1;
    endtask

    task automatic do_csr(input logic [1:0] op, input logic [11:0] addr, input logic [63:0] wd,
                          input logic [63:0] exp_rd, input logic exp_ill, input logic chk_rd);
        logic ok;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        resp_q.push_back({chk_rd, exp_ill, exp_rd});
        wait_accept("csr_accept_timeout", ok);
        req_valid = 1'b0;
        if (!ok) void'(resp_q.pop_back());
    endtask

    task automatic do_trap(input logic [63:0] cause, input logic [63:0] pc, input logic [63:0] tval,
                           input logic [63:0] exp_pc);
        logic ok;
        trap_valid = 1'b1; trap_cause = cause; trap_pc = pc; trap_tval = tval;
        redir_q.push_back(exp_pc);
        wait_accept("trap_accept_timeout", ok);
        trap_valid = 1'b0;
        if (!ok) void'(redir_q.pop_back());
    endtask

    task automatic do_mret(input logic [63:0] exp_pc);
        logic ok;
        mret_valid = 1'b1;
        redir_q.push_back(exp_pc);
        wait_accept("mret_accept_timeout", ok);
        mret_valid = 1'b0;
        if (!ok) void'(redir_q.pop_back());
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = 12'd0; req_wdata = 64'd0;
        trap_valid = 1'b0; trap_cause = 64'd0; trap_pc = 64'd0; trap_tval = 64'd0;
        mret_valid = 1'b0; irq_mtip = 1'b0; irq_msip = 1'b0; irq_meip = 1'b0;

        vecs[0]  = '{2'b01, 12'h305, 64'h8000_0100,          64'd0,       1'b0, 1'b1, 64'h8000_0100};
        vecs[1]  = '{2'b10, 12'h300, 64'h8,                  64'd0,       1'b0, 1'b1, 64'h8};
        vecs[2]  = '{2'b11, 12'h300, 64'h8,                  64'h8,       1'b0, 1'b1, 64'h0};
        vecs[3]  = '{2'b01, 12'h300, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,      1'b0, 1'b1, 64'h1888};
        vecs[4]  = '{2'b01, 12'h300, 64'h8,                  64'h1888,    1'b0, 1'b1, 64'h8};
        vecs[5]  = '{2'b01, 12'h341, 64'h1237,               64'd0,       1'b0, 1'b1, 64'h1234};
        vecs[6]  = '{2'b10, 12'h340, 64'hF0,                 64'd0,       1'b0, 1'b1, 64'hF0};
        vecs[7]  = '{2'b11, 12'h340, 64'h30,                 64'hF0,      1'b0, 1'b1, 64'hC0};
        vecs[8]  = '{2'b01, 12'h304, 64'h888,                64'd0,       1'b0, 1'b1, 64'h888};
        vecs[9]  = '{2'b01, 12'hF14, 64'hDEAD,               64'd5,       1'b0, 1'b1, 64'd5};
        vecs[10] = '{2'b01, 12'h344, 64'hFFFF,               64'd0,       1'b0, 1'b1, 64'd0};
        vecs[11] = '{2'b01, 12'h180, 64'hABCD,               64'd0,       1'b0, 1'b1, 64'hABCD};
        vecs[12] = '{2'b01, 12'h7C0, 64'h55,                 64'd0,       1'b1, 1'b0, 64'd0};
        vecs[13] = '{2'b10, 12'h342, 64'h0,                  64'd0,       1'b0, 1'b1, 64'd0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check64("rst_ready", {63'd0, ready}, 64'd0);
        check64("rst_mhartid", csr.mhartid, 64'd5);
        check64("rst_mstatus", csr.mstatus, 64'd0);
        check64("rst_mcycle", csr.mcycle, 64'd0);
        check64("rst_strobes", {62'd0, resp_valid, redirect_valid}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check64("ready_after_rst", {63'd0, ready}, 64'd1);
        settle();
        check64("mcycle_first_tick", csr.mcycle, 64'd1);

        // Table of CSR instructions
        for (int i = 0; i < 14; i++) begin
            do_csr(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_ill, 1'b1);
            check64("ready_low_after_accept", {63'd0, ready}, 64'd0);
            settle();
            if (vecs[i].has_after) check64("vec_after", field_of(csr, vecs[i].addr), vecs[i].exp_after);
        end
        check64("illegal_no_change_mscratch", csr.mscratch, 64'hC0);

        // Op 00 is not a request
        req_valid = 1'b1; req_op = 2'b00; req_addr = 12'h340; req_wdata = 64'h1;
        settle();
        @(negedge clk);
        check64("op00_ignored", {62'd0, ready, resp_valid}, 64'd2);
        req_valid = 1'b0;

        // Interrupt pending path
        irq_mtip = 1'b1;
        settle();
        check64("mip_mtip", csr.mip, 64'h80);
        check64("irq_pending_on", {63'd0, irq_pending}, 64'd1);
        irq_mtip = 1'b0; irq_meip = 1'b1;
        settle();
        check64("mip_meip", csr.mip, 64'h800);
        irq_meip = 1'b0;
        settle();
        check64("irq_pending_off", {63'd0, irq_pending}, 64'd0);

        // Direct trap, then mret
        do_trap(64'd11, 64'h8000_0010, 64'd0, 64'h8000_0100);
        settle();
        check64("trap1_mepc", csr.mepc, 64'h8000_0010);
        check64("trap1_mcause", csr.mcause, 64'd11);
        check64("trap1_mstatus", csr.mstatus, 64'h1880);
        do_mret(64'h8000_0010);
        settle();
        check64("mret_mstatus", csr.mstatus, 64'h88);

        // Vectored interrupt, then exception in vectored mode
        do_csr(2'b01, 12'h305, 64'h8000_0101, 64'h8000_0100, 1'b0, 1'b1);
        settle();
        do_trap(64'h8000_0000_0000_0007, 64'h8000_0022, 64'hBEEF, 64'h8000_011C);
        settle();
        check64("trap2_mepc", csr.mepc, 64'h8000_0020);
        check64("trap2_mcause", csr.mcause, 64'h8000_0000_0000_0007);
        check64("trap2_mtval", csr.mtval, 64'hBEEF);
        check64("trap2_mstatus", csr.mstatus, 64'h1880);
        do_trap(64'd2, 64'h8000_0040, 64'd0, 64'h8000_0100);
        settle();
        check64("trap3_mstatus", csr.mstatus, 64'h1800);

        // Trap and CSR request together: trap first, request held
        trap_valid = 1'b1; trap_cause = 64'd3; trap_pc = 64'h100; trap_tval = 64'd0;
        req_valid = 1'b1; req_op = 2'b10; req_addr = 12'h340; req_wdata = 64'd0;
        redir_q.push_back(64'h8000_0100);
        resp_q.push_back({1'b1, 1'b0, 64'hC0});
        @(negedge clk);
        check64("prio_ready", {63'd0, ready}, 64'd1);
        settle();
        trap_valid = 1'b0;
        @(negedge clk);
        check64("prio_trap_first", {61'd0, ready, redirect_valid, resp_valid}, 64'd2);
        @(negedge clk);
        check64("prio_req_held", {61'd0, ready, redirect_valid, resp_valid}, 64'd4);
        settle();
        req_valid = 1'b0;
        @(negedge clk);
        check64("prio_req_resp", {63'd0, resp_valid}, 64'd1);
        settle();

        // mcycle write wins over increment
        do_csr(2'b01, 12'hB00, 64'h100, 64'd0, 1'b0, 1'b0);
        settle();
        check64("mcycle_written", csr.mcycle, 64'h100);
        settle();
        check64("mcycle_next", csr.mcycle, 64'h101);

        // Reset during CSR_WB and TRAP_WB
        req_valid = 1'b1; req_op = 2'b01; req_addr = 12'h340; req_wdata = 64'h999;
        @(negedge clk);
        settle();
        req_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        check64("rst_mid_csr_strobe", {62'd0, resp_valid, ready}, 64'd0);
        settle();
        reset = 1'b0;
        check64("rst_mid_mscratch", csr.mscratch, 64'd0);
        trap_valid = 1'b1; trap_cause = 64'd2; trap_pc = 64'h40; trap_tval = 64'd0;
        @(negedge clk);
        settle();
        trap_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        check64("rst_mid_trap_strobe", {63'd0, redirect_valid}, 64'd0);
        settle();
        reset = 1'b0;
        check64("rst_mid_mepc", csr.mepc, 64'd0);
        @(negedge clk);
        check64("rst_mid_idle", {63'd0, ready}, 64'd1);

        repeat (3) settle();
        check64("resp_q_drained", 64'(resp_q.size()), 64'd0);
        check64("redir_q_drained", 64'(redir_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
